uart_tx_serializer: RTL

Transmit-side UART serializer that consumes the one-clock `tx_baud` bit-period strobe from the TX baud generator and shifts a parallel data word onto the serial line. Each frame is: start bit, DATA_BITS data bits LSB-first, an optional parity bit, then one or two stop bits. It sits between the TX request source (register interface or FIFO) and the pad-side `tx` line. Upstream handshake is valid/ready.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_serializer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: frame states, line levels and
// parity mode encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_mode_e;

  // Data is zero-extended to 8 bits, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input parity_mode_e mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity and one
// or two stop bits, with every bit advanced by the external tx_baud strobe.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tx_baud,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_en_q, parity_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      parity_en_q  <= 1'b0;
      two_stop_q   <= 1'b0;
      parity_q     <= 1'b0;
      tx_q         <= IDLE_LEVEL;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_en_q  <= parity_en_d;
      two_stop_q   <= two_stop_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // tx_d is the level of the state being entered, so tx stays purely registered.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_en_d  = parity_en_q;
    two_stop_d   = two_stop_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (data_valid) begin
          state_d     = WAIT;
          shift_d     = data_in;
          parity_en_d = parity_en;
          two_stop_d  = two_stop;
          parity_d    = calc_parity(8'(data_in), parity_mode_e'(parity_odd));
        end
      end
      // A strobe coincident with acceptance is not seen here, so the start
      // bit always spans a full period.
      WAIT: begin
        if (tx_baud) begin
          state_d = START;
          tx_d    = START_LEVEL;
        end
      end
      START: begin
        if (tx_baud) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (tx_baud) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (parity_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = IDLE_LEVEL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tx_baud) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (tx_baud) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d      = IDLE;
            stop_cnt_d   = 1'b0;
            frame_done_d = 1'b1;
          end
          tx_d = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

endmodule
